// File: rtl/cpu_bus_pkg.sv
// +----------------------------------------------------------------------------+
// | cpu_bus_pkg: CPU-side bus address map and DMA initiator state encoding.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cpu_bus_pkg;

    localparam logic [15:0] ADDR_SPR_RAM_DMA  = 16'h4014;
    localparam logic [15:0] ADDR_SPR_RAM_DATA = 16'h2004;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

endpackage

`default_nettype wire

// File: rtl/spr_dma_master.sv
// +----------------------------------------------------------------------------+
// | spr_dma_master: snoops the SPR-RAM DMA trigger, stalls the CPU and copies  |
// | one page to the SPR-RAM data register. Revision: 1.0                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module spr_dma_master
    import cpu_bus_pkg::*;
#(
    parameter logic [15:0] REG_ADDR  = ADDR_SPR_RAM_DMA,
    parameter logic [15:0] DEST_ADDR = ADDR_SPR_RAM_DATA,
    parameter int          XFER_LEN  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr_out,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_wen,
    output logic        cpu_rdy,
    output logic        dma_busy,
    output logic [15:0] dma_addr_out,
    output logic [7:0]  dma_data_out,
    output logic        dma_ren,
    output logic        dma_wen,
    input  logic [7:0]  dma_data_in
);

    localparam logic [8:0] c_LAST_IDX = 9'(XFER_LEN - 1);

    dma_state_t  r_state;
    dma_state_t  w_state_next;
    logic [7:0]  r_page;
    logic [7:0]  w_page_next;
    logic [8:0]  r_idx;
    logic [8:0]  w_idx_next;
    logic        r_cycle_odd;
    logic [7:0]  r_data;

    logic        r_cpu_rdy;
    logic        r_dma_busy;
    logic [15:0] r_dma_addr;
    logic        r_dma_ren;
    logic        r_dma_wen;

    logic        w_cpu_rdy_next;
    logic        w_dma_busy_next;
    logic [15:0] w_dma_addr_next;
    logic        w_dma_ren_next;
    logic        w_dma_wen_next;
    logic        w_trigger;

    // CPU signals only reach the bus in IDLE, so snooping is limited to that state.
    assign w_trigger = cpu_wen && (cpu_addr_out == REG_ADDR) && (r_state == IDLE);

    always_comb begin
        w_state_next = r_state;
        w_page_next  = r_page;
        w_idx_next   = r_idx;
        unique case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_state_next = HALT;
                    w_page_next  = cpu_data_out;
                    w_idx_next   = 9'd0;
                end
            end
            HALT:  w_state_next = r_cycle_odd ? READ : ALIGN;
            ALIGN: w_state_next = READ;
            READ:  w_state_next = WRITE;
            WRITE: begin
                w_idx_next   = r_idx + 9'd1;
                w_state_next = (r_idx == c_LAST_IDX) ? IDLE : READ;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_cpu_rdy_next  = 1'b1;
        w_dma_busy_next = 1'b0;
        w_dma_addr_next = 16'h0000;
        w_dma_ren_next  = 1'b0;
        w_dma_wen_next  = 1'b0;
        unique case (w_state_next)
            HALT, ALIGN: begin
                w_cpu_rdy_next  = 1'b0;
                w_dma_busy_next = 1'b1;
            end
            READ: begin
                w_cpu_rdy_next  = 1'b0;
                w_dma_busy_next = 1'b1;
                w_dma_ren_next  = 1'b1;
                w_dma_addr_next = {w_page_next, w_idx_next[7:0]};
            end
            WRITE: begin
                w_cpu_rdy_next  = 1'b0;
                w_dma_busy_next = 1'b1;
                w_dma_wen_next  = 1'b1;
                w_dma_addr_next = DEST_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_page      <= 8'h00;
            r_idx       <= 9'd0;
            r_cycle_odd <= 1'b0;
            r_data      <= 8'h00;
            r_cpu_rdy   <= 1'b1;
            r_dma_busy  <= 1'b0;
            r_dma_addr  <= 16'h0000;
            r_dma_ren   <= 1'b0;
            r_dma_wen   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_page      <= w_page_next;
            r_idx       <= w_idx_next;
            r_cycle_odd <= ~r_cycle_odd;
            if (r_state == READ) begin
                r_data <= dma_data_in;
            end
            r_cpu_rdy   <= w_cpu_rdy_next;
            r_dma_busy  <= w_dma_busy_next;
            r_dma_addr  <= w_dma_addr_next;
            r_dma_ren   <= w_dma_ren_next;
            r_dma_wen   <= w_dma_wen_next;
        end
    end

    assign cpu_rdy      = r_cpu_rdy;
    assign dma_busy     = r_dma_busy;
    assign dma_addr_out = r_dma_addr;
    assign dma_data_out = r_data;
    assign dma_ren      = r_dma_ren;
    assign dma_wen      = r_dma_wen;

endmodule

`default_nettype wire

// File: tb/tb_spr_dma_master.sv
// +----------------------------------------------------------------------------+
// | tb_spr_dma_master: self-checking bench for the SPR-RAM DMA initiator.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spr_dma_master;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_addr_out;
    logic [7:0]  cpu_data_out;
    logic        cpu_wen;
    logic        cpu_rdy;
    logic        dma_busy;
    logic [15:0] dma_addr_out;
    logic [7:0]  dma_data_out;
    logic        dma_ren;
    logic        dma_wen;
    logic [7:0]  dma_data_in;

    logic [7:0]  ram [0:65535];
    logic [7:0]  wdata_log [0:255];
    int          edge_cnt;
    int          checks;
    int          errors;

    spr_dma_master dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr_out (cpu_addr_out),
        .cpu_data_out (cpu_data_out),
        .cpu_wen      (cpu_wen),
        .cpu_rdy      (cpu_rdy),
        .dma_busy     (dma_busy),
        .dma_addr_out (dma_addr_out),
        .dma_data_out (dma_data_out),
        .dma_ren      (dma_ren),
        .dma_wen      (dma_wen),
        .dma_data_in  (dma_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: read data is combinationally valid with the read strobe.
    assign dma_data_in = dma_ren ? ram[dma_addr_out] : 8'h00;

    // Clock edges since reset release; parity of this count is the CPU get/put phase.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_rdy"},  {31'd0, cpu_rdy},  32'd1);
        check({name, "_busy"}, {31'd0, dma_busy}, 32'd0);
        check({name, "_ren"},  {31'd0, dma_ren},  32'd0);
        check({name, "_wen"},  {31'd0, dma_wen},  32'd0);
    endtask

    // Trigger a transfer of `page` at the current negedge and check every beat.
    // abort_wr > 0 asserts reset during that WRITE beat and returns early.
    task automatic run_xfer(input logic [7:0] page, input int abort_wr);
        int stall    = 0;
        int rd       = 0;
        int wr       = 0;
        int first_rd = -1;
        bit done     = 0;
        int exp_stall;
        exp_stall    = (((edge_cnt + 1) % 2) == 1) ? 513 : 514;
        cpu_addr_out = 16'h4014;
        cpu_data_out = page;
        cpu_wen      = 1'b1;
        for (int c = 0; c < 700 && !done; c++) begin
            @(negedge clk);
            // The CPU keeps writing junk pages early on; none may be snooped.
            if (c < 40) begin
                cpu_addr_out = 16'h4014;
                cpu_data_out = ~page;
                cpu_wen      = 1'b1;
            end else begin
                cpu_wen = 1'b0;
            end
            if (c == 0) check("stall_start", {31'd0, cpu_rdy}, 32'd0);
            check("strobe_excl", {31'd0, dma_ren & dma_wen}, 32'd0);
            if (!cpu_rdy) begin
                stall++;
                check("busy_in_stall", {31'd0, dma_busy}, 32'd1);
            end else begin
                done = 1;
                check_idle("end");
            end
            if (dma_ren) begin
                if (first_rd < 0) first_rd = c;
                check("rd_addr", {16'd0, dma_addr_out}, {16'd0, page, rd[7:0]});
                rd++;
            end
            if (dma_wen) begin
                check("wr_addr", {16'd0, dma_addr_out}, 32'h2004);
                check("wr_data", {24'd0, dma_data_out}, {24'd0, ram[{page, wr[7:0]}]});
                if (wr < 256) wdata_log[wr] = dma_data_out;
                wr++;
                if (abort_wr > 0 && wr == abort_wr) begin
                    rst     = 1'b1;
                    cpu_wen = 1'b0;
                    #1;
                    check_idle("async_rst");
                    return;
                end
            end
        end
        check("completed",  {31'd0, done}, 32'd1);
        check("stall_len",  stall,    exp_stall);
        check("reads",      rd,       32'd256);
        check("writes",     wr,       32'd256);
        check("first_read", first_rd, exp_stall - 512);
        cpu_wen = 1'b0;
    endtask

    task automatic wait_parity(input bit odd);
        for (int i = 0; i < 2 && ((((edge_cnt + 1) % 2) == 1) != odd); i++) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        wen;
        logic        exp_rdy;
        logic        exp_busy;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        cpu_addr_out = 16'h0000;
        cpu_data_out = 8'h00;
        cpu_wen      = 1'b0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) wdata_log[i] = 8'h00;

        vecs[0] = '{16'h4015, 8'h12, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{16'h2004, 8'h34, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{16'h4014, 8'h56, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h4013, 8'h02, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{16'h4014, 8'h09, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h0014, 8'h40, 1'b1, 1'b1, 1'b0};

        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        check("reset_addr", {16'd0, dma_addr_out}, 32'h0);
        check("reset_data", {24'd0, dma_data_out}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            cpu_addr_out = vecs[v].addr;
            cpu_data_out = vecs[v].data;
            cpu_wen      = vecs[v].wen;
            @(negedge clk);
            check($sformatf("vec%0d_rdy", v),  {31'd0, cpu_rdy},  {31'd0, vecs[v].exp_rdy});
            check($sformatf("vec%0d_busy", v), {31'd0, dma_busy}, {31'd0, vecs[v].exp_busy});
            cpu_wen = 1'b0;
            if (vecs[v].exp_busy) begin
                for (int c = 0; c < 700 && !cpu_rdy; c++) @(negedge clk);
                check($sformatf("vec%0d_done", v), {31'd0, cpu_rdy}, 32'd1);
            end
        end

        wait_parity(1'b1);
        run_xfer(8'h02, 0);
        @(negedge clk);
        wait_parity(1'b0);
        run_xfer(8'h02, 0);

        for (int i = 0; i < 256; i++) ram[16'h0300 + i] = 8'(i) ^ 8'hA5;
        @(negedge clk);
        run_xfer(8'h03, 0);
        check("integ_w0",   {24'd0, wdata_log[0]},   32'hA5);
        check("integ_w1",   {24'd0, wdata_log[1]},   32'hA4);
        check("integ_w255", {24'd0, wdata_log[255]}, 32'h5A);

        @(negedge clk);
        run_xfer(8'h05, 100);
        @(posedge clk);
        #1;
        check_idle("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("post_rst");
        end
        run_xfer(8'h05, 0);

        @(negedge clk);
        run_xfer(8'h07, 0);
        run_xfer(8'h08, 0);

        for (int t = 0; t < 6; t++) begin
            logic [7:0] pg;
            int         gap;
            pg  = 8'($urandom);
            gap = $urandom_range(0, 3);
            for (int i = 0; i < 256; i++) ram[{pg, 8'(i)}] = 8'($urandom);
            for (int g = 0; g < gap; g++) @(negedge clk);
            run_xfer(pg, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
